// File: rtl/ahb_mem_slave_pkg.sv
// Bus encodings and FSM states shared by the AHB-lite memory responder.
package ahb_mem_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  function automatic logic is_xfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  // Only states that drive HREADYOUT high may take a new address phase.
  function automatic logic can_accept(input state_t s);
    return (s == S_IDLE) || (s == S_DATA) || (s == S_ERR2);
  endfunction

endpackage

// File: rtl/ahb_sram_core.sv
// DEPTH x 32 word store: synchronous write, asynchronous read, cleared on reset.
module ahb_sram_core #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-lite responder in front of a word RAM: wait states, OKAY/ERROR responses and
// back-to-back pipelined transfers with write-to-read forwarding.
module ahb_mem_slave
  import ahb_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        HCLK_i,
  input  logic        HRESET_i,
  input  logic        HSEL_i,
  input  logic [31:0] HADDR_bi,
  input  logic [1:0]  HTRANS_bi,
  input  logic        HWRITE_i,
  input  logic [31:0] HWDATA_bi,
  input  logic        HREADY_i,
  output logic [31:0] HRDATA_bo,
  output logic        HREADYOUT_o,
  output logic        HRESP_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic [31:0]   off;
  logic [AW-1:0] addr_idx, rd_idx;
  logic [31:0]   ram_rdata;
  logic          addr_err, accept, fwd_hit, ram_we;

  assign off      = HADDR_bi - BASE_ADDR;
  assign addr_idx = off[AW+1:2];
  assign addr_err = (off >= SPAN) || (HADDR_bi[1:0] != 2'b00);
  assign accept   = can_accept(state_q) && HSEL_i && HREADY_i && is_xfer(HTRANS_bi);

  // The read port follows the transfer that will own the next DATA cycle.
  assign rd_idx  = accept ? addr_idx : idx_q;
  assign fwd_hit = (state_q == S_DATA) && write_q && (idx_q == rd_idx);
  assign ram_we  = (state_q == S_DATA) && write_q;

  ahb_sram_core #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_sram (
    .clk  (HCLK_i),
    .rst  (HRESET_i),
    .we   (ram_we),
    .waddr(idx_q),
    .wdata(HWDATA_bi),
    .raddr(rd_idx),
    .rdata(ram_rdata)
  );

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    hrdata_d = '0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      idx_d   = addr_idx;
      write_d = HWRITE_i;
      if (addr_err) begin
        state_d = S_ERR1;
      end else if (WAIT_CYCLES > 0) begin
        state_d = S_WAIT;
        cnt_d   = WAIT_INIT;
      end else begin
        state_d = S_DATA;
      end
    end
    // Write-first: a read landing on the word being written this cycle sees the new data.
    if ((state_d == S_DATA) && !write_d) hrdata_d = fwd_hit ? HWDATA_bi : ram_rdata;
  end

  always_comb begin
    HREADYOUT_o = 1'b1;
    HRESP_o     = HRESP_OKAY;
    case (state_q)
      S_WAIT: HREADYOUT_o = 1'b0;
      S_ERR1: begin
        HREADYOUT_o = 1'b0;
        HRESP_o     = HRESP_ERROR;
      end
      S_ERR2:  HRESP_o = HRESP_ERROR;
      default: ;
    endcase
  end

  assign HRDATA_bo = hrdata_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomised scoreboard bench: three responder configurations, each with its own master
// driver and cycle-by-cycle monitor checking against a word-array reference model.
module tb_ahb_mem_slave;

  localparam int NCFG  = 3;
  localparam int DEPTH = 64;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          block;
    bit          rst;
  } item_t;

  typedef struct {
    int          acc_cyc;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_bad = 0;
  logic done_a [NCFG];

  task automatic check(input string name, input int cfg, input logic [33:0] act,
                       input logic [33:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cfg%0d cyc%0d: got ready=%b resp=%b rdata=%h, want ready=%b resp=%b rdata=%h",
               name, cfg, cyc, act[33], act[32], act[31:0], want[33], want[32], want[31:0]);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int          WC   = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
    localparam logic [31:0] BASE = (gi == 1) ? 32'h4000_0000 : 32'h0000_0000;

    logic        rst, hsel, hwrite, blk, hready, hreadyout, hresp, done;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, hrdata;
    exp_t        exp_q[$];
    item_t       q[$];
    logic [31:0] mem_m [DEPTH];

    assign hready    = hreadyout & ~blk;
    assign done_a[gi] = done;

    ahb_mem_slave #(
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .WAIT_CYCLES(WC)
    ) dut (
      .HCLK_i     (clk),
      .HRESET_i   (rst),
      .HSEL_i     (hsel),
      .HADDR_bi   (haddr),
      .HTRANS_bi  (htrans),
      .HWRITE_i   (hwrite),
      .HWDATA_bi  (hwdata),
      .HREADY_i   (hready),
      .HRDATA_bo  (hrdata),
      .HREADYOUT_o(hreadyout),
      .HRESP_o    (hresp)
    );

    function automatic item_t mk(input bit sel, input logic [1:0] tr, input bit wr,
                                 input logic [31:0] off, input logic [31:0] wd,
                                 input bit b, input bit r);
      item_t it;
      it.sel = sel; it.trans = tr; it.write = wr; it.addr = BASE + off;
      it.wdata = wd; it.block = b; it.rst = r;
      return it;
    endfunction

    task automatic idle();
      q.push_back(mk(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
    endtask

    task automatic drive(input item_t it);
      hsel = it.sel; htrans = it.trans; hwrite = it.write; haddr = it.addr; blk = it.block;
    endtask

    task automatic build_items();
      // write then read, and a write immediately followed by a read of the same word
      q.push_back(mk(1, T_NSEQ, 1, 32'h10, 32'hDEADBEEF, 0, 0));
      q.push_back(mk(1, T_NSEQ, 0, 32'h10, 32'h0, 0, 0));
      idle();
      q.push_back(mk(1, T_NSEQ, 1, 32'h04, 32'h12345678, 0, 0));
      q.push_back(mk(1, T_SEQ, 0, 32'h04, 32'h0, 0, 0));
      idle();
      // out of range, unaligned, then a read of the neighbouring word
      q.push_back(mk(1, T_NSEQ, 0, 32'h100, 32'h0, 0, 0));
      q.push_back(mk(1, T_NSEQ, 1, 32'h22, 32'hFFFFFFFF, 0, 0));
      q.push_back(mk(1, T_NSEQ, 0, 32'h20, 32'h0, 0, 0));
      idle();
      // deselected, BUSY, and HREADY held low: none may touch the RAM
      q.push_back(mk(0, T_NSEQ, 1, 32'h08, 32'hA5A5A5A5, 0, 0));
      q.push_back(mk(1, T_BUSY, 1, 32'h08, 32'hA5A5A5A5, 0, 0));
      idle();
      q.push_back(mk(1, T_NSEQ, 1, 32'h08, 32'hA5A5A5A5, 1, 0));
      idle();
      q.push_back(mk(1, T_NSEQ, 0, 32'h08, 32'h0, 0, 0));
      idle();
      // top word and first word past the end
      q.push_back(mk(1, T_NSEQ, 1, 32'hFC, 32'hCAFE0001, 0, 0));
      q.push_back(mk(1, T_NSEQ, 0, 32'hFC, 32'h0, 0, 0));
      q.push_back(mk(1, T_NSEQ, 0, 32'h100, 32'h0, 0, 0));
      idle();
      // reset lands in the second data-phase cycle of a write
      q.push_back(mk(1, T_NSEQ, 1, 32'h3C, 32'h1, 0, 0));
      q.push_back(mk(1, T_NSEQ, 0, 32'h3C, 32'h0, 0, 0));
      idle();
      q.push_back(mk(1, T_NSEQ, 1, 32'h3C, 32'h2, 0, 0));
      q.push_back(mk(0, T_IDLE, 0, 32'h0, 32'h0, 0, 1));
      idle();
      q.push_back(mk(1, T_NSEQ, 0, 32'h3C, 32'h0, 0, 0));
      idle();
      for (int i = 0; i < 200; i++) begin
        logic [31:0] off;
        logic [1:0]  tr;
        off = 32'($urandom_range(0, DEPTH + 3)) << 2;
        if ($urandom_range(0, 7) == 0) off[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) off = $urandom;
        case ($urandom_range(0, 5))
          0:       tr = T_IDLE;
          1:       tr = T_BUSY;
          2, 3:    tr = T_NSEQ;
          default: tr = T_SEQ;
        endcase
        if ($urandom_range(0, 9) == 0) begin
          idle();
          q.push_back(mk(1, T_NSEQ, 1'($urandom_range(0, 1)), off, $urandom, 1, 0));
        end else begin
          q.push_back(mk(1'($urandom_range(0, 9) != 0), tr, 1'($urandom_range(0, 1)),
                         off, $urandom, 0, 0));
        end
      end
      for (int i = 0; i < 10; i++) idle();
    endtask

    initial begin : drv
      item_t       cur, dp;
      bit          dp_v, rdy, acc;
      logic [31:0] off;
      exp_t        e;
      rst = 1'b1; hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = '0;
      hwdata = '0; blk = 1'b0; done = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      build_items();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      dp_v = 1'b0;
      cur = mk(0, T_IDLE, 0, 32'h0, 32'h0, 0, 0);
      drive(cur);
      while (1) begin
        @(negedge clk);
        // junk on HWDATA except in the cycle where the write really completes
        if (dp_v && dp.write) hwdata = hreadyout ? dp.wdata : $urandom;
        else                  hwdata = $urandom;
        rdy = hready;
        @(posedge clk);
        #1;
        if (rdy || cur.block) begin
          acc  = cur.sel && rdy && cur.trans[1];
          dp_v = 1'b0;
          if (acc) begin
            off       = cur.addr - BASE;
            e.acc_cyc = cyc;
            e.err     = (off >= 32'(DEPTH * 4)) || (cur.addr[1:0] != 2'b00);
            e.rdata   = '0;
            if (!e.err) begin
              if (cur.write) mem_m[off / 4] = cur.wdata;
              else           e.rdata = mem_m[off / 4];
            end
            exp_q.push_back(e);
            dp   = cur;
            dp_v = !e.err;
          end
          if (q.size() == 0) break;
          cur = q.pop_front();
          if (cur.rst) begin
            cur = mk(0, T_IDLE, 0, 32'h0, 32'h0, 0, 0);
            drive(cur);
            @(posedge clk);
            #3 rst = 1'b1;
            @(posedge clk);
            #3 rst = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            dp_v = 1'b0;
          end
          drive(cur);
        end
      end
      repeat (3) @(negedge clk);
      done = 1'b1;
    end

    initial begin : mon
      exp_t        ce;
      bit          act;
      int          k;
      logic [33:0] want;
      act = 1'b0;
      k   = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          check("reset", gi, {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
          exp_q.delete();
          act = 1'b0;
        end else begin
          if (!act && exp_q.size() > 0 && exp_q[0].acc_cyc <= cyc) begin
            ce  = exp_q.pop_front();
            act = 1'b1;
            k   = 0;
          end
          if (act) begin
            if (ce.err) want = (k == 0) ? {1'b0, 1'b1, 32'h0} : {1'b1, 1'b1, 32'h0};
            else        want = (k < WC) ? {1'b0, 1'b0, 32'h0} : {1'b1, 1'b0, ce.rdata};
            check(ce.err ? "err_phase" : "okay_phase", gi, {hreadyout, hresp, hrdata}, want);
            k++;
            if (k == (ce.err ? 2 : WC + 1)) act = 1'b0;
          end else begin
            check("idle", gi, {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
          end
        end
      end
    end
  end

  initial begin : main
    int c;
    c = 0;
    while (c < 20000 && !(done_a[0] === 1'b1 && done_a[1] === 1'b1 && done_a[2] === 1'b1)) begin
      @(posedge clk);
      c++;
    end
    if (c >= 20000) begin
      n_bad++;
      $display("FAIL timeout: drivers not finished after %0d cycles, want all done", c);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
